// File: rtl/mux_rr_feeder_if.sv
// Handshake and data bundle between the four input channels, the feeder and the 4:1 bus multiplexer.
// Latency: none; wires only.
// Backpressure: carries in_ready per channel and out_ready from downstream.
interface mux_rr_feeder_if #(
    parameter int BUS_WIDTH = 5
);
    logic [3:0]           in_valid;
    logic [BUS_WIDTH-1:0] in_data0;
    logic [BUS_WIDTH-1:0] in_data1;
    logic [BUS_WIDTH-1:0] in_data2;
    logic [BUS_WIDTH-1:0] in_data3;
    logic [3:0]           in_ready;
    logic [BUS_WIDTH-1:0] D0;
    logic [BUS_WIDTH-1:0] D1;
    logic [BUS_WIDTH-1:0] D2;
    logic [BUS_WIDTH-1:0] D3;
    logic [1:0]           sel;
    logic                 out_valid;
    logic                 out_ready;
    logic [2:0]           pending;

    // Environment side: producers on the four channels plus the downstream consumer.
    modport master (
        output in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
        input  in_ready, D0, D1, D2, D3, sel, out_valid, pending
    );

    // Feeder side.
    modport slave (
        input  in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
        output in_ready, D0, D1, D2, D3, sel, out_valid, pending
    );
endinterface

// File: rtl/mux_rr_feeder.sv
// Four one-entry channel buffers feeding a 4:1 mux, with round-robin sel and an output valid/ready handshake.
// Latency: 2 edges minimum from in_valid to out_valid (capture, then grant); back-to-back grants while several are full.
// Backpressure: out_ready low freezes sel/out_valid/D; a full channel drops in_ready until its word is transferred.
module mux_rr_feeder #(
    parameter int BUS_WIDTH = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    mux_rr_feeder_if.slave bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t               state;
    logic [3:0]           full;
    logic [3:0]           full_nx;
    logic [3:0]           capture;
    logic [3:0]           grant_mask;
    logic [3:0]           release_mask;
    logic [BUS_WIDTH-1:0] dreg    [4];
    logic [BUS_WIDTH-1:0] in_word [4];
    logic [1:0]           sel_q;
    logic [1:0]           ptr;
    logic                 out_valid_q;
    logic [2:0]           pending_q;
    logic                 xfer;
    logic [2:0]           pick_idle;
    logic [2:0]           pick_next;

    // Returns {found, index} of the first set bit of f scanning start, start+1, ... modulo 4.
    function automatic logic [2:0] first_full(input logic [3:0] f, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        // Scan from the far end so the nearest hit to start is the one that sticks.
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (f[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    function automatic logic [2:0] popcount4(input logic [3:0] f);
        return {2'b00, f[0]} + {2'b00, f[1]} + {2'b00, f[2]} + {2'b00, f[3]};
    endfunction

    // Capture/release decode and next-grant search; eligibility uses the flags as they stand this cycle.
    always_comb begin
        in_word[0]   = bus.in_data0;
        in_word[1]   = bus.in_data1;
        in_word[2]   = bus.in_data2;
        in_word[3]   = bus.in_data3;
        capture      = bus.in_valid & ~full;
        xfer         = (state == GRANT) && bus.out_ready;
        grant_mask   = 4'b0001 << sel_q;
        release_mask = xfer ? grant_mask : 4'b0000;
        full_nx      = (full & ~release_mask) | capture;
        pick_idle    = first_full(full, ptr);
        pick_next    = first_full(full & ~grant_mask, sel_q + 2'd1);
    end

    // Holding registers, occupancy flags and their registered popcount.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full      <= 4'b0000;
            pending_q <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                dreg[i] <= '0;
            end
        end else begin
            full      <= full_nx;
            pending_q <= popcount4(full_nx);
            for (int i = 0; i < 4; i++) begin
                if (capture[i]) begin
                    dreg[i] <= in_word[i];
                end
            end
        end
    end

    // Grant FSM: picks the next full channel in rotating order and holds it until downstream accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sel_q       <= 2'd0;
            ptr         <= 2'd0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_idle[2]) begin
                        sel_q       <= pick_idle[1:0];
                        out_valid_q <= 1'b1;
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    if (bus.out_ready) begin
                        ptr <= sel_q + 2'd1;
                        if (pick_next[2]) begin
                            sel_q <= pick_next[1:0];
                        end else begin
                            out_valid_q <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.in_ready  = ~full;
    assign bus.D0        = dreg[0];
    assign bus.D1        = dreg[1];
    assign bus.D2        = dreg[2];
    assign bus.D3        = dreg[3];
    assign bus.sel       = sel_q;
    assign bus.out_valid = out_valid_q;
    assign bus.pending   = pending_q;

endmodule
